fifo_sync_ext: RTL and testbench
================================

# fifo_sync_ext

Parametrised single-clock FIFO, the next generation of our synchronous FIFO. It adds a selectable first-word-fall-through (FWFT) read mode and full-depth occupancy (all 2^ADDR_WIDTH entries usable). It also adds registered almost-full/almost-empty flags with parametrised thresholds, and sticky, separately reported overrun/underrun flags with an explicit clear. It sits between producer/consumer blocks in the same clock domain, e.g. pixel/stream buffering ahead of DMA or UART paths.

## Interface
- DATA_WIDTH, 8: word width in bits.
- ADDR_WIDTH, 9: log2 of depth; DEPTH = 2^ADDR_WIDTH, all entries usable.
- FWFT, 0: 0 = standard read (data one cycle after accepted read); 1 = first-word-fall-through.
- AF_THRESH, DEPTH-4: o_almost_full asserted when fill >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 4: o_almost_empty asserted when fill <= AE_THRESH; legal range 0..DEPTH-1.
- i_clk  in  1  clock; all logic on rising edge.
- i_rstn  in  1  synchronous, active-low reset.
- i_wr  in  1  write request.
- i_data  in  DATA_WIDTH  write data.
- i_rd  in  1  read request (FWFT: acknowledge of current o_data).
- i_err_clr  in  1  clears sticky error flags.
- o_data  out  DATA_WIDTH  read data.
- o_valid  out  1  standard: one-cycle pulse, o_data updated; FWFT: o_data holds head word.
- o_fill  out  ADDR_WIDTH+1  stored word count, 0..DEPTH.
- o_full  out  1  fill == DEPTH.
- o_empty  out  1  standard: fill == 0; FWFT: !o_valid.
- o_almost_full  out  1  registered, fill >= AF_THRESH.
- o_almost_empty  out  1  registered, fill <= AE_THRESH.
- o_overrun  out  1  sticky: a write was rejected.
- o_underrun  out  1  sticky: a read was rejected.

## Operation
- Read accept: rd_ok = i_rd && !o_empty. Write accept: wr_ok = i_wr && (!o_full || rd_ok).
- Rejected write does not modify memory or wptr; rejected read does not move rptr or o_data.
- Pointers are ADDR_WIDTH bits and wrap modulo DEPTH. fill is ADDR_WIDTH+1 bits; next = fill + wr_ok - rd_ok, never outside 0..DEPTH.
- Simultaneous read and write:
  - Full: both accepted, fill unchanged, o_full stays 1.
  - Empty: read rejected (underrun set), write accepted, fill goes to 1.
- Standard mode: rd_ok at edge N loads mem[rptr] into o_data; o_valid is 1 for the cycle after edge N only. o_data holds its value otherwise.
- FWFT mode:
  - An internal prefetch moves the head word into o_data whenever o_valid == 0 and the RAM holds data, or on rd_ok when another word is stored.
  - fill counts the prefetched word.
- Errors: o_overrun set on i_wr && !wr_ok; o_underrun set on i_rd && !rd_ok. i_err_clr clears both; a set in the same cycle wins over the clear.
- All status outputs are registered from next-state values, so o_fill, o_full, o_empty and the almost flags change on the same edge.

## Timing
- Reset (i_rstn low at an edge): o_fill 0, o_empty 1, o_full 0, o_almost_empty 1, o_almost_full 0, o_valid 0, o_data 0, o_overrun 0, o_underrun 0; pointers 0.
- Reset mid-operation discards all contents; memory array is not cleared.
- Standard read latency: 1 cycle from accepted i_rd to o_data/o_valid.
- FWFT write-to-valid latency on empty FIFO: write sampled at edge N, o_valid 1 after edge N+1. In that cycle o_fill is 1 while o_empty is 1.
- FWFT back-to-back reads: o_valid stays 1 with a new word each cycle while fill > 1. There are no bubbles.
- Flag update latency: 1 edge after the accepted operation.

## Structure
- Package fifo_pkg holds:
  - the FWFT mode constants (FIFO_MODE_STD = 0, FIFO_MODE_FWFT = 1);
  - a function computing default thresholds from ADDR_WIDTH;
  - a status-vector bit-index constant set shared with existing o_status consumers.
- Sub-module fifo_ram_sdp: simple dual-port RAM, one write port and one registered read port with read enable, parametrised DATA_WIDTH/ADDR_WIDTH. The FIFO control, prefetch and flags stay in fifo_sync_ext.

## Test plan
- Reset, then write 0x01..0x04 with ADDR_WIDTH=2, FWFT=0 -> o_fill 4, o_full 1; a fifth write sets o_overrun and o_fill stays 4. Reading 4 words returns 0x01..0x04, each one cycle after i_rd, then o_empty 1.
- Empty FIFO, i_rd && i_wr of 0xA5 together -> o_underrun 1, o_fill 1. The next read returns 0xA5.
- Full FIFO (DEPTH 4), read and write 0x55 in the same cycle -> no error, o_fill 4, o_full 1. After draining, 0x55 is the last word out.
- FWFT=1: write 0x3C at edge N -> o_valid 1 and o_data 0x3C after edge N+1. Then write 3 words and hold i_rd high -> words out on 4 consecutive cycles, then o_valid 0.
- AF_THRESH=3, AE_THRESH=1, DEPTH 4: fill sweeps 0->4->0 -> o_almost_empty 1 at fill 0..1, o_almost_full 1 at fill 3..4, both coincident with o_fill.
- Set o_overrun, then pulse i_err_clr -> cleared next edge. i_err_clr with a simultaneous rejected read -> o_underrun stays 1. Assert i_rstn low mid-stream -> all outputs return to their reset values next edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous FIFO family: read-mode selectors,
// default almost-full/almost-empty thresholds and status-vector bit positions.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Bit positions inside the packed o_status word read by existing consumers
    localparam int ST_EMPTY    = 0;
    localparam int ST_FULL     = 1;
    localparam int ST_AEMPTY   = 2;
    localparam int ST_AFULL    = 3;
    localparam int ST_OVERRUN  = 4;
    localparam int ST_UNDERRUN = 5;
    localparam int ST_VALID    = 6;
    localparam int ST_WIDTH    = 7;

    function automatic int default_af_thresh(input int addr_width);
        int depth;
        depth = 1 << addr_width;
        return (depth > 4) ? depth - 4 : depth;
    endfunction

    function automatic int default_ae_thresh(input int addr_width);
        int depth;
        depth = 1 << addr_width;
        return (depth > 16) ? 4 : depth / 4;
    endfunction

endpackage

// File: rtl/fifo_ram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
// Only the read register is reset; the array itself keeps its contents.
module fifo_ram_sdp #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    // Read-before-write: a same-address read returns the old word
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            o_rdata <= '0;
        end else if (i_re) begin
            o_rdata <= mem_q[i_raddr];
        end
    end

endmodule

// File: rtl/fifo_sync_ext.sv
// Single-clock FIFO with standard or first-word-fall-through read, full-depth
// occupancy, registered almost flags and sticky overrun/underrun reporting.
module fifo_sync_ext
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9,
    parameter int FWFT       = FIFO_MODE_STD,
    parameter int AF_THRESH  = default_af_thresh(ADDR_WIDTH),
    parameter int AE_THRESH  = default_ae_thresh(ADDR_WIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_wr,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_rd,
    input  logic                  i_err_clr,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic [ADDR_WIDTH:0]   o_fill,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almost_full,
    output logic                  o_almost_empty,
    output logic                  o_overrun,
    output logic                  o_underrun
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0]   AF_L    = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0]   AE_L    = (ADDR_WIDTH+1)'(AE_THRESH);
    localparam logic [ADDR_WIDTH:0]   ONE_F   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ONE_P   = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wptr_q, rptr_q;
    logic [ADDR_WIDTH:0]   fill_q, fill_d, ram_cnt;
    logic                  valid_q, valid_d, empty_q, empty_d;
    logic                  full_q, af_q, ae_q, ovr_q, unr_q;
    logic                  rd_ok, wr_ok, ram_re;

    always_comb begin
        rd_ok   = i_rd && !empty_q;
        wr_ok   = i_wr && (!full_q || rd_ok);
        fill_d  = fill_q;
        if (wr_ok && !rd_ok) begin
            fill_d = fill_q + ONE_F;
        end else if (rd_ok && !wr_ok) begin
            fill_d = fill_q - ONE_F;
        end
        // In FWFT mode the word parked in the output register is part of fill
        ram_cnt = valid_q ? fill_q - ONE_F : fill_q;
        if (FWFT == FIFO_MODE_FWFT) begin
            ram_re  = (ram_cnt != '0) && (!valid_q || rd_ok);
            valid_d = ram_re || (valid_q && !rd_ok);
            empty_d = !valid_d;
        end else begin
            ram_re  = rd_ok;
            valid_d = rd_ok;
            empty_d = (fill_d == '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            fill_q  <= '0;
            valid_q <= 1'b0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovr_q   <= 1'b0;
            unr_q   <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr_q <= wptr_q + ONE_P;
            end
            if (ram_re) begin
                rptr_q <= rptr_q + ONE_P;
            end
            fill_q  <= fill_d;
            valid_q <= valid_d;
            empty_q <= empty_d;
            full_q  <= (fill_d == DEPTH_L);
            af_q    <= (fill_d >= AF_L);
            ae_q    <= (fill_d <= AE_L);
            // A new error in the same cycle as the clear keeps the flag set
            ovr_q   <= (i_wr && !wr_ok) || (ovr_q && !i_err_clr);
            unr_q   <= (i_rd && !rd_ok) || (unr_q && !i_err_clr);
        end
    end

    fifo_ram_sdp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_we    (wr_ok && i_rstn),
        .i_waddr (wptr_q),
        .i_wdata (i_data),
        .i_re    (ram_re && i_rstn),
        .i_raddr (rptr_q),
        .o_rdata (o_data)
    );

    assign o_valid        = valid_q;
    assign o_fill         = fill_q;
    assign o_full         = full_q;
    assign o_empty        = empty_q;
    assign o_almost_full  = af_q;
    assign o_almost_empty = ae_q;
    assign o_overrun      = ovr_q;
    assign o_underrun     = unr_q;

endmodule

// File: tb/tb_fifo_sync_ext.sv
// Drives a standard-mode and an FWFT-mode FIFO (depth 4, AF=3, AE=1) with the
// same inputs and checks both against queue-based reference models.
module tb_fifo_sync_ext;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rstn, wr, rd, clr;
    logic [7:0] din;

    logic [7:0] s_data, f_data;
    logic [2:0] s_fill, f_fill;
    logic       s_valid, s_full, s_empty, s_af, s_ae, s_ovr, s_unr;
    logic       f_valid, f_full, f_empty, f_af, f_ae, f_ovr, f_unr;

    always #5 clk = ~clk;

    fifo_sync_ext #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(0), .AF_THRESH(3), .AE_THRESH(1)) dut_s (
        .i_clk(clk), .i_rstn(rstn), .i_wr(wr), .i_data(din), .i_rd(rd), .i_err_clr(clr),
        .o_data(s_data), .o_valid(s_valid), .o_fill(s_fill), .o_full(s_full), .o_empty(s_empty),
        .o_almost_full(s_af), .o_almost_empty(s_ae), .o_overrun(s_ovr), .o_underrun(s_unr)
    );

    fifo_sync_ext #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(1), .AF_THRESH(3), .AE_THRESH(1)) dut_f (
        .i_clk(clk), .i_rstn(rstn), .i_wr(wr), .i_data(din), .i_rd(rd), .i_err_clr(clr),
        .o_data(f_data), .o_valid(f_valid), .o_fill(f_fill), .o_full(f_full), .o_empty(f_empty),
        .o_almost_full(f_af), .o_almost_empty(f_ae), .o_overrun(f_ovr), .o_underrun(f_unr)
    );

    int n_checks = 0;
    int n_err    = 0;
    int edge_n   = 0;

    // Reference state: stored words as queues; FWFT entries remember their write edge
    typedef struct {
        logic [7:0] d;
        int         t;
    } fent_t;

    logic [7:0] sq[$];
    fent_t      fq[$];
    logic       m_sval, m_sovr, m_sunr, m_fval, m_fovr, m_funr;
    logic [7:0] m_sdata;

    task automatic model_edge(input bit r_n, input bit w, input logic [7:0] d, input bit r, input bit c);
        bit rok, wok;
        if (!r_n) begin
            sq.delete();
            fq.delete();
            m_sval = 0; m_sovr = 0; m_sunr = 0; m_sdata = 8'h00;
            m_fval = 0; m_fovr = 0; m_funr = 0;
            return;
        end
        rok = r && (sq.size() != 0);
        wok = w && (sq.size() != DEPTH || rok);
        m_sval = rok;
        if (rok) m_sdata = sq.pop_front();
        if (wok) sq.push_back(d);
        m_sovr = (w && !wok) ? 1'b1 : (c ? 1'b0 : m_sovr);
        m_sunr = (r && !rok) ? 1'b1 : (c ? 1'b0 : m_sunr);
        // FWFT: the head becomes visible once it was written at least one edge earlier
        rok = r && m_fval;
        wok = w && (fq.size() != DEPTH || rok);
        if (rok) void'(fq.pop_front());
        if (wok) fq.push_back('{d: d, t: edge_n});
        m_fval = (fq.size() != 0) && (fq[0].t <= edge_n - 1);
        m_fovr = (w && !wok) ? 1'b1 : (c ? 1'b0 : m_fovr);
        m_funr = (r && !rok) ? 1'b1 : (c ? 1'b0 : m_funr);
    endtask

    task automatic step(input bit r_n, input bit w, input logic [7:0] d, input bit r, input bit c);
        rstn = r_n; wr = w; din = d; rd = r; clr = c;
        @(posedge clk);
        edge_n++;
        model_edge(r_n, w, d, r, c);
        #1;
        $display("edge=%0d rstn=%0b wr=%0b d=%02h rd=%0b clr=%0b | std fill=%0d v=%0b q=%02h | fwft fill=%0d v=%0b q=%02h",
                 edge_n, r_n, w, d, r, c, s_fill, s_valid, s_data, f_fill, f_valid, f_data);
    endtask

    task automatic test_reset();
        step(0, 0, 8'h00, 0, 0);
        n_checks++;
        if ({s_fill, s_full, s_empty, s_af, s_ae, s_valid, s_ovr, s_unr, s_data} !== {3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL reset_std: got fill=%0d full=%0b empty=%0b af=%0b ae=%0b v=%0b ovr=%0b unr=%0b d=%02h, want 0 0 1 0 1 0 0 0 00",
                     s_fill, s_full, s_empty, s_af, s_ae, s_valid, s_ovr, s_unr, s_data);
        end
        n_checks++;
        if ({f_fill, f_full, f_empty, f_af, f_ae, f_valid, f_ovr, f_unr, f_data} !== {3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL reset_fwft: got fill=%0d full=%0b empty=%0b af=%0b ae=%0b v=%0b ovr=%0b unr=%0b d=%02h, want 0 0 1 0 1 0 0 0 00",
                     f_fill, f_full, f_empty, f_af, f_ae, f_valid, f_ovr, f_unr, f_data);
        end
    endtask

    task automatic test_fill_overrun();
        for (int i = 1; i <= 4; i++) step(1, 1, 8'(i), 0, 0);
        n_checks++;
        if ({s_fill, s_full} !== {3'd4, 1'b1}) begin
            n_err++;
            $display("FAIL fill_full: got fill=%0d full=%0b, want 4 1", s_fill, s_full);
        end
        step(1, 1, 8'h05, 0, 0);
        n_checks++;
        if ({s_ovr, s_fill} !== {1'b1, 3'd4}) begin
            n_err++;
            $display("FAIL overrun_set: got ovr=%0b fill=%0d, want 1 4", s_ovr, s_fill);
        end
        for (int i = 1; i <= 4; i++) begin
            step(1, 0, 8'h00, 1, 0);
            n_checks++;
            if ({s_valid, s_data} !== {1'b1, 8'(i)}) begin
                n_err++;
                $display("FAIL std_read%0d: got v=%0b d=%02h, want 1 %02h", i, s_valid, s_data, 8'(i));
            end
        end
        step(1, 0, 8'h00, 0, 0);
        n_checks++;
        if ({s_valid, s_empty, s_data} !== {1'b0, 1'b1, 8'h04}) begin
            n_err++;
            $display("FAIL drained: got v=%0b empty=%0b d=%02h, want 0 1 04", s_valid, s_empty, s_data);
        end
    endtask

    task automatic test_empty_rw();
        step(1, 1, 8'hA5, 1, 0);
        n_checks++;
        if ({s_unr, s_fill, s_valid} !== {1'b1, 3'd1, 1'b0}) begin
            n_err++;
            $display("FAIL empty_rw: got unr=%0b fill=%0d v=%0b, want 1 1 0", s_unr, s_fill, s_valid);
        end
        step(1, 0, 8'h00, 1, 0);
        n_checks++;
        if ({s_valid, s_data} !== {1'b1, 8'hA5}) begin
            n_err++;
            $display("FAIL empty_rw_read: got v=%0b d=%02h, want 1 a5", s_valid, s_data);
        end
    endtask

    task automatic test_full_rw();
        logic [7:0] exp_out [4];
        exp_out = '{8'h11, 8'h12, 8'h13, 8'h55};
        step(1, 0, 8'h00, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 1, 8'h10 + 8'(i), 0, 0);
        step(1, 1, 8'h55, 1, 0);
        n_checks++;
        if ({s_ovr, s_unr, s_fill, s_full, s_valid, s_data} !== {1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 8'h10}) begin
            n_err++;
            $display("FAIL full_rw: got ovr=%0b unr=%0b fill=%0d full=%0b v=%0b d=%02h, want 0 0 4 1 1 10",
                     s_ovr, s_unr, s_fill, s_full, s_valid, s_data);
        end
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 8'h00, 1, 0);
            n_checks++;
            if ({s_valid, s_data} !== {1'b1, exp_out[i]}) begin
                n_err++;
                $display("FAIL full_rw_drain%0d: got v=%0b d=%02h, want 1 %02h", i, s_valid, s_data, exp_out[i]);
            end
        end
    endtask

    task automatic test_thresholds();
        int k;
        step(0, 0, 8'h00, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            k = (i <= 4) ? i : 8 - i;
            step(1, i <= 4, 8'(i), i > 4, 0);
            n_checks++;
            if ({s_fill, s_af, s_ae} !== {3'(k), k >= 3, k <= 1}) begin
                n_err++;
                $display("FAIL thresh_fill%0d: got fill=%0d af=%0b ae=%0b, want %0d %0b %0b",
                         k, s_fill, s_af, s_ae, k, k >= 3, k <= 1);
            end
        end
    endtask

    task automatic test_errors();
        for (int i = 0; i < 5; i++) step(1, 1, 8'(i), 0, 0);
        step(1, 0, 8'h00, 0, 1);
        n_checks++;
        if (s_ovr !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_clear: got ovr=%0b, want 0", s_ovr);
        end
        for (int i = 0; i < 4; i++) step(1, 0, 8'h00, 1, 0);
        step(1, 0, 8'h00, 1, 0);
        step(1, 0, 8'h00, 1, 1);
        n_checks++;
        if (s_unr !== 1'b1) begin
            n_err++;
            $display("FAIL unr_set_wins: got unr=%0b, want 1", s_unr);
        end
        step(1, 0, 8'h00, 0, 1);
        n_checks++;
        if (s_unr !== 1'b0) begin
            n_err++;
            $display("FAIL unr_clear: got unr=%0b, want 0", s_unr);
        end
    endtask

    task automatic test_fwft();
        logic [7:0] exp_out [3];
        exp_out = '{8'hA1, 8'hA2, 8'hA3};
        step(0, 0, 8'h00, 0, 0);
        step(1, 1, 8'h3C, 0, 0);
        n_checks++;
        if ({f_valid, f_fill, f_empty} !== {1'b0, 3'd1, 1'b1}) begin
            n_err++;
            $display("FAIL fwft_latency0: got v=%0b fill=%0d empty=%0b, want 0 1 1", f_valid, f_fill, f_empty);
        end
        step(1, 0, 8'h00, 0, 0);
        n_checks++;
        if ({f_valid, f_data, f_empty} !== {1'b1, 8'h3C, 1'b0}) begin
            n_err++;
            $display("FAIL fwft_latency1: got v=%0b d=%02h empty=%0b, want 1 3c 0", f_valid, f_data, f_empty);
        end
        for (int i = 0; i < 3; i++) step(1, 1, exp_out[i], 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 8'h00, 1, 0);
            n_checks++;
            if (i < 3 && {f_valid, f_data} !== {1'b1, exp_out[i]}) begin
                n_err++;
                $display("FAIL fwft_b2b%0d: got v=%0b d=%02h, want 1 %02h", i, f_valid, f_data, exp_out[i]);
            end else if (i == 3 && {f_valid, f_empty, f_fill} !== {1'b0, 1'b1, 3'd0}) begin
                n_err++;
                $display("FAIL fwft_b2b_end: got v=%0b empty=%0b fill=%0d, want 0 1 0", f_valid, f_empty, f_fill);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1, 1, 8'h21, 0, 0);
        step(1, 1, 8'h22, 1, 0);
        step(0, 1, 8'h77, 1, 0);
        n_checks++;
        if ({s_fill, s_full, s_empty, s_af, s_ae, s_valid, s_ovr, s_unr, s_data} !== {3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL midreset_std: got fill=%0d empty=%0b v=%0b d=%02h", s_fill, s_empty, s_valid, s_data);
        end
        n_checks++;
        if ({f_fill, f_full, f_empty, f_af, f_ae, f_valid, f_ovr, f_unr, f_data} !== {3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL midreset_fwft: got fill=%0d empty=%0b v=%0b d=%02h", f_fill, f_empty, f_valid, f_data);
        end
    endtask

    task automatic test_random();
        logic [17:0] exp_s, got_s;
        logic [9:0]  exp_f, got_f;
        int          wr_pct;
        for (int i = 0; i < 300; i++) begin
            wr_pct = ((i / 24) % 2 == 0) ? 75 : 25;
            step($urandom_range(63) != 0, $urandom_range(99) < wr_pct, 8'($urandom),
                 $urandom_range(99) < 100 - wr_pct, $urandom_range(15) == 0);
            exp_s = {3'(sq.size()), sq.size() == DEPTH, sq.size() == 0, sq.size() >= 3, sq.size() <= 1,
                     m_sval, m_sovr, m_sunr, m_sdata};
            got_s = {s_fill, s_full, s_empty, s_af, s_ae, s_valid, s_ovr, s_unr, s_data};
            n_checks++;
            if (got_s !== exp_s) begin
                n_err++;
                $display("FAIL rand_std@%0d: got %05h want %05h (fill,full,empty,af,ae,v,ovr,unr,data)", edge_n, got_s, exp_s);
            end
            exp_f = {3'(fq.size()), fq.size() == DEPTH, !m_fval, fq.size() >= 3, fq.size() <= 1,
                     m_fval, m_fovr, m_funr};
            got_f = {f_fill, f_full, f_empty, f_af, f_ae, f_valid, f_ovr, f_unr};
            n_checks++;
            if (got_f !== exp_f) begin
                n_err++;
                $display("FAIL rand_fwft@%0d: got %03h want %03h (fill,full,empty,af,ae,v,ovr,unr)", edge_n, got_f, exp_f);
            end
            if (m_fval) begin
                n_checks++;
                if (f_data !== fq[0].d) begin
                    n_err++;
                    $display("FAIL rand_fwft_data@%0d: got %02h want %02h", edge_n, f_data, fq[0].d);
                end
            end
        end
    endtask

    initial begin
        rstn = 1'b0; wr = 1'b0; rd = 1'b0; clr = 1'b0; din = 8'h00;
        step(0, 0, 8'h00, 0, 0);
        test_reset();
        test_fill_overrun();
        test_empty_rw();
        test_full_rw();
        test_thresholds();
        test_errors();
        test_fwft();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
